// File: rtl/decode_stage.sv
// RV32I decode stage: registered decode bundle with valid/ready handshake.
// Illegal encodings still flow downstream, flagged, so a later stage can trap.
package decode_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_EQ   = 4'd5;
  localparam logic [3:0] ALU_NE   = 4'd6;
  localparam logic [3:0] ALU_LT   = 4'd7;
  localparam logic [3:0] ALU_GE   = 4'd8;
  localparam logic [3:0] ALU_LTU  = 4'd9;
  localparam logic [3:0] ALU_GEU  = 4'd10;
  localparam logic [3:0] ALU_SLL  = 4'd11;
  localparam logic [3:0] ALU_SRL  = 4'd12;
  localparam logic [3:0] ALU_SRA  = 4'd13;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        src1_pc;
    logic        src2_imm;
    logic        reg_we;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } id_ex_t;

endpackage

module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        src1_pc,
  output logic        src2_imm,
  output logic        reg_we,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        is_load,
  output logic        is_store,
  output logic        illegal
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] shamt;
  logic        shift;
  logic        ok;
  id_ex_t      d;
  id_ex_t      q;

  assign op    = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign shift = (f3[1:0] == 2'b01);

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};
  assign shamt = {27'b0, inst[24:20]};

  // alt selects SUB/SRA over ADD/SRL
  function automatic logic [3:0] alu_of(
    input logic [2:0] fn,
    input logic       alt
  );
    unique case (fn)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_LT;
      3'b011:  alu_of = ALU_LTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  always_comb begin
    d          = '0;
    ok         = 1'b1;
    d.pc       = pc_in;
    d.rs1      = inst[19:15];
    d.rs2      = inst[24:20];
    d.rd       = inst[11:7];
    d.alu_ctrl = ALU_ADD;
    unique case (1'b1)
      op == OPC_LUI: begin
        d.rs1      = '0;
        d.imm      = imm_u;
        d.src2_imm = 1'b1;
        d.reg_we   = 1'b1;
      end
      op == OPC_AUIPC: begin
        d.imm      = imm_u;
        d.src1_pc  = 1'b1;
        d.src2_imm = 1'b1;
        d.reg_we   = 1'b1;
      end
      op == OPC_JAL: begin
        d.imm      = imm_j;
        d.src1_pc  = 1'b1;
        d.src2_imm = 1'b1;
        d.is_jal   = 1'b1;
        d.reg_we   = 1'b1;
      end
      op == OPC_JALR: begin
        ok         = (f3 == 3'b000);
        d.imm      = imm_i;
        d.src2_imm = 1'b1;
        d.is_jalr  = 1'b1;
        d.reg_we   = 1'b1;
      end
      op == OPC_BRANCH: begin
        d.imm       = imm_b;
        d.is_branch = 1'b1;
        unique case (f3)
          3'b000:  d.alu_ctrl = ALU_EQ;
          3'b001:  d.alu_ctrl = ALU_NE;
          3'b100:  d.alu_ctrl = ALU_LT;
          3'b101:  d.alu_ctrl = ALU_GE;
          3'b110:  d.alu_ctrl = ALU_LTU;
          3'b111:  d.alu_ctrl = ALU_GEU;
          default: ok = 1'b0;
        endcase
      end
      op == OPC_LOAD: begin
        ok         = (f3 inside {3'b000, 3'b001, 3'b010,
                                 3'b100, 3'b101});
        d.imm      = imm_i;
        d.src2_imm = 1'b1;
        d.is_load  = 1'b1;
        d.reg_we   = 1'b1;
      end
      op == OPC_STORE: begin
        ok         = (f3 inside {3'b000, 3'b001, 3'b010});
        d.imm      = imm_s;
        d.src2_imm = 1'b1;
        d.is_store = 1'b1;
      end
      op == OPC_OPIMM: begin
        ok         = !shift || (f7 == 7'h00) ||
                     (f3[2] && (f7 == 7'h20));
        d.imm      = shift ? shamt : imm_i;
        d.alu_ctrl = alu_of(f3, shift & f7[5]);
        d.src2_imm = 1'b1;
        d.reg_we   = 1'b1;
      end
      op == OPC_OP: begin
        ok         = (f7 == 7'h00) ||
                     ((f7 == 7'h20) &&
                      ((f3 == 3'b000) || (f3 == 3'b101)));
        d.alu_ctrl = alu_of(f3, f7[5]);
        d.reg_we   = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d.alu_ctrl  = ALU_ADD;
      d.imm       = '0;
      d.src1_pc   = 1'b0;
      d.src2_imm  = 1'b0;
      d.reg_we    = 1'b0;
      d.is_branch = 1'b0;
      d.is_jal    = 1'b0;
      d.is_jalr   = 1'b0;
      d.is_load   = 1'b0;
      d.is_store  = 1'b0;
      d.illegal   = 1'b1;
    end
    if (d.rd == 5'd0) d.reg_we = 1'b0;
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      q         <= d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign pc_out    = q.pc;
  assign alu_ctrl  = q.alu_ctrl;
  assign rs1       = q.rs1;
  assign rs2       = q.rs2;
  assign rd        = q.rd;
  assign imm       = q.imm;
  assign src1_pc   = q.src1_pc;
  assign src2_imm  = q.src2_imm;
  assign reg_we    = q.reg_we;
  assign is_branch = q.is_branch;
  assign is_jal    = q.is_jal;
  assign is_jalr   = q.is_jalr;
  assign is_load   = q.is_load;
  assign is_store  = q.is_store;
  assign illegal   = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors plus random traffic
// checked against a mask/match opcode-table reference model.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        src1_pc;
  logic        src2_imm;
  logic        reg_we;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic        is_load;
  logic        is_store;
  logic        illegal;

  int errors;
  int checks;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .alu_ctrl(alu_ctrl),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .src1_pc(src1_pc), .src2_imm(src2_imm),
    .reg_we(reg_we), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr),
    .is_load(is_load), .is_store(is_store),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] RM = 32'hFE00707F;
  localparam logic [31:0] IM = 32'h0000707F;
  localparam logic [31:0] OM = 32'h0000007F;
  localparam logic [3:0] FR = 0, FI = 1, FSH = 2, FB = 3, FL = 4;
  localparam logic [3:0] FS = 5, FJR = 6, FJ = 7, FLUI = 8, FAUI = 9;
  localparam int NENT = 37;

  // RV32I instruction table: mask, match, ALU op, operand format
  function automatic void entry(input int k, output logic [31:0] m,
                                output logic [31:0] mt,
                                output logic [3:0] a,
                                output logic [3:0] f);
    case (k)
      0:  {m, mt, a, f} = {RM, 32'h00000033, 4'd2,  FR};
      1:  {m, mt, a, f} = {RM, 32'h40000033, 4'd3,  FR};
      2:  {m, mt, a, f} = {RM, 32'h00001033, 4'd11, FR};
      3:  {m, mt, a, f} = {RM, 32'h00002033, 4'd7,  FR};
      4:  {m, mt, a, f} = {RM, 32'h00003033, 4'd9,  FR};
      5:  {m, mt, a, f} = {RM, 32'h00004033, 4'd4,  FR};
      6:  {m, mt, a, f} = {RM, 32'h00005033, 4'd12, FR};
      7:  {m, mt, a, f} = {RM, 32'h40005033, 4'd13, FR};
      8:  {m, mt, a, f} = {RM, 32'h00006033, 4'd1,  FR};
      9:  {m, mt, a, f} = {RM, 32'h00007033, 4'd0,  FR};
      10: {m, mt, a, f} = {IM, 32'h00000013, 4'd2,  FI};
      11: {m, mt, a, f} = {IM, 32'h00002013, 4'd7,  FI};
      12: {m, mt, a, f} = {IM, 32'h00003013, 4'd9,  FI};
      13: {m, mt, a, f} = {IM, 32'h00004013, 4'd4,  FI};
      14: {m, mt, a, f} = {IM, 32'h00006013, 4'd1,  FI};
      15: {m, mt, a, f} = {IM, 32'h00007013, 4'd0,  FI};
      16: {m, mt, a, f} = {RM, 32'h00001013, 4'd11, FSH};
      17: {m, mt, a, f} = {RM, 32'h00005013, 4'd12, FSH};
      18: {m, mt, a, f} = {RM, 32'h40005013, 4'd13, FSH};
      19: {m, mt, a, f} = {IM, 32'h00000063, 4'd5,  FB};
      20: {m, mt, a, f} = {IM, 32'h00001063, 4'd6,  FB};
      21: {m, mt, a, f} = {IM, 32'h00004063, 4'd7,  FB};
      22: {m, mt, a, f} = {IM, 32'h00005063, 4'd8,  FB};
      23: {m, mt, a, f} = {IM, 32'h00006063, 4'd9,  FB};
      24: {m, mt, a, f} = {IM, 32'h00007063, 4'd10, FB};
      25: {m, mt, a, f} = {IM, 32'h00000003, 4'd2,  FL};
      26: {m, mt, a, f} = {IM, 32'h00001003, 4'd2,  FL};
      27: {m, mt, a, f} = {IM, 32'h00002003, 4'd2,  FL};
      28: {m, mt, a, f} = {IM, 32'h00004003, 4'd2,  FL};
      29: {m, mt, a, f} = {IM, 32'h00005003, 4'd2,  FL};
      30: {m, mt, a, f} = {IM, 32'h00000023, 4'd2,  FS};
      31: {m, mt, a, f} = {IM, 32'h00001023, 4'd2,  FS};
      32: {m, mt, a, f} = {IM, 32'h00002023, 4'd2,  FS};
      33: {m, mt, a, f} = {IM, 32'h00000067, 4'd2,  FJR};
      34: {m, mt, a, f} = {OM, 32'h0000006F, 4'd2,  FJ};
      35: {m, mt, a, f} = {OM, 32'h00000037, 4'd2,  FLUI};
      default: {m, mt, a, f} = {OM, 32'h00000017, 4'd2, FAUI};
    endcase
  endfunction

  function automatic logic [91:0] obs();
    return {pc_out, alu_ctrl, rs1, rs2, rd, imm, src1_pc, src2_imm,
            reg_we, is_branch, is_jal, is_jalr, is_load, is_store,
            illegal};
  endfunction

  // expected bundle e and care mask c (0 = field left open)
  function automatic void model(input logic [31:0] i,
                                input logic [31:0] p,
                                output logic [91:0] e,
                                output logic [91:0] c);
    logic [31:0] m, mt, im, sx;
    logic [3:0]  a, fk, f, ah;
    logic [4:0]  r1;
    logic        hit, s1p, s2i, we, br, jl, jr, ld, st, il;
    logic        cr1, cr2, crd, cim, cs2;
    hit = 0; f = FR; ah = 4'd2;
    for (int k = 0; k < NENT; k++) begin
      entry(k, m, mt, a, fk);
      if (!hit && ((i & m) == mt)) begin
        hit = 1; f = fk; ah = a;
      end
    end
    sx = {32{i[31]}};
    r1 = i[19:15]; im = 32'd0;
    {s1p, s2i, we, br, jl, jr, ld, st, il} = 9'd0;
    {cr1, cr2, crd, cim, cs2} = 5'h1F;
    if (!hit) begin
      il = 1; ah = 4'd2;
      {cr1, cr2, crd, cim, cs2} = 5'h0;
    end else begin
      case (f)
        FR:  begin we = 1; cim = 0; end
        FI:  begin we = 1; s2i = 1; im = i >>> 20 | (sx << 12); end
        FSH: begin we = 1; s2i = 1; im = (i >> 20) & 32'd31; end
        FB:  begin
          br = 1;
          im = (sx << 12) | (32'(i[7]) << 11) |
               (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        end
        FL:  begin we = 1; s2i = 1; ld = 1; im = (i >> 20) | (sx << 12); end
        FS:  begin
          s2i = 1; st = 1;
          im = (sx << 12) | (32'(i[31:25]) << 5) | 32'(i[11:7]);
        end
        FJR: begin we = 1; s2i = 1; jr = 1; im = (i >> 20) | (sx << 12); end
        FJ:  begin
          we = 1; s2i = 1; s1p = 1; jl = 1; cr1 = 0; cr2 = 0;
          im = (sx << 20) | (32'(i[19:12]) << 12) |
               (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        end
        FLUI: begin we = 1; s2i = 1; r1 = 0; cr2 = 0; im = i & 32'hFFFFF000; end
        default: begin
          we = 1; s2i = 1; s1p = 1; cr1 = 0; cr2 = 0;
          im = i & 32'hFFFFF000;
        end
      endcase
    end
    if (i[11:7] == 5'd0) we = 0;
    e = {p, ah, r1, i[24:20], i[11:7], im, s1p, s2i,
         we, br, jl, jr, ld, st, il};
    c = {{32{1'b1}}, 4'hF, {5{cr1}}, {5{cr2}}, {5{crd}},
         {32{cim}}, 1'b1, cs2, 7'h7F};
  endfunction

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    @(negedge clk);
    in_valid = 1'b1; inst = i; pc_in = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, obs()} !== 93'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {out_valid, obs()});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_ready: got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    send(32'h002081B3, 32'h0000_0100);
    checks++;
    if ({out_valid, alu_ctrl, rs1, rs2, rd, reg_we, src2_imm, pc_out} !==
        {1'b1, 4'd2, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL add: got v=%b alu=%0d rs=%0d,%0d rd=%0d we=%b si=%b pc=%h want 1 2 1,2 3 1 0 100",
               out_valid, alu_ctrl, rs1, rs2, rd, reg_we, src2_imm, pc_out);
    end
    send(32'hFE209EE3, 32'h0000_0104);
    checks++;
    if ({alu_ctrl, is_branch, imm, reg_we} !==
        {4'd6, 1'b1, 32'hFFFFFFFC, 1'b0}) begin
      errors++;
      $display("FAIL bne: got alu=%0d br=%b imm=%h we=%b want 6 1 fffffffc 0",
               alu_ctrl, is_branch, imm, reg_we);
    end
    send(32'h4030D093, 32'h0000_0108);
    checks++;
    if ({alu_ctrl, imm, src2_imm, reg_we} !== {4'd13, 32'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL srai: got alu=%0d imm=%h si=%b we=%b want 13 3 1 1",
               alu_ctrl, imm, src2_imm, reg_we);
    end
    send(32'h00000013, 32'h0000_010C);
    checks++;
    if ({out_valid, reg_we, illegal} !== 3'b100) begin
      errors++;
      $display("FAIL nop_we: got %b want 100", {out_valid, reg_we, illegal});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_hold();
    logic [91:0] ea, ca, eb, cb;
    model(32'h4030D093, 32'h200, ea, ca);
    model(32'hFE209EE3, 32'h300, eb, cb);
    out_ready = 1'b0;
    send(32'h4030D093, 32'h200);
    in_valid = 1'b1; inst = 32'hFE209EE3; pc_in = 32'h300;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_ready: got %b want 0", in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || (obs() & ca) !== (ea & ca)) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got v=%b r=%b %h want 1 0 %h",
                 k, out_valid, in_ready, obs() & ca, ea & ca);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || (obs() & cb) !== (eb & cb)) begin
      errors++;
      $display("FAIL release_next: got v=%b %h want 1 %h",
               out_valid, obs() & cb, eb & cb);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h002081B3, 32'h400);
    in_valid = 1'b1; inst = 32'h00000013; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b1;
    send(32'hFFFFFFFF, 32'h404);
    checks++;
    if ({out_valid, illegal, reg_we, alu_ctrl} !== {3'b110, 4'd2}) begin
      errors++;
      $display("FAIL illegal_all1: got v=%b il=%b we=%b alu=%0d want 1 1 0 2",
               out_valid, illegal, reg_we, alu_ctrl);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(32'h002081B3, 32'h500);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, pc_out} !== {2'b01, 32'd0}) begin
      errors++;
      $display("FAIL async_reset: got v=%b r=%b pc=%h want 0 1 0",
               out_valid, in_ready, pc_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic        mv;
    logic [91:0] me, mc, e, c;
    logic [31:0] m, mt, ri;
    logic [3:0]  a, f;
    int          r;
    mv = 1'b0; me = '0; mc = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== mv ||
          (mv && (obs() & mc) !== (me & mc))) begin
        errors++;
        $display("FAIL rand_bundle[%0d]: got v=%b %h want %b %h",
                 n, out_valid, obs() & mc, mv, me & mc);
      end
      r = $urandom_range(0, 9);
      entry($urandom_range(0, NENT - 1), m, mt, a, f);
      ri = ($urandom & ~m) | mt;
      if (r == 7) ri = $urandom;
      if (r == 8) ri = (ri & ~32'h3) | 32'($urandom_range(0, 2));
      inst      = ri;
      pc_in     = $urandom & 32'hFFFFFFFC;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      checks++;
      if (in_ready !== (!mv || out_ready)) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b want %b",
                 n, in_ready, !mv || out_ready);
      end
      if (flush) mv = 1'b0;
      else if (in_valid && (!mv || out_ready)) begin
        model(ri, pc_in, e, c);
        mv = 1'b1; me = e; mc = c;
      end else if (out_ready) mv = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    inst = 32'd0; pc_in = 32'd0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_hold();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
- REQ-001: The block SHALL have no parameters.
- REQ-002: clk  input  1  Single clock; all state updates on the rising edge.
- REQ-003: rst_n  input  1  Reset, asynchronous and active-low.
- REQ-004: flush  input  1  Synchronous pipeline flush.
- REQ-005: in_valid  input  1  Instruction word present.
- REQ-006: in_ready  output  1  Stage can accept an instruction.
- REQ-007: inst  input  32  RV32I instruction word.
- REQ-008: pc_in  input  32  Address of inst.
- REQ-009: out_valid  output  1  Decoded bundle present.
- REQ-010: out_ready  input  1  Downstream accepts the bundle.
- REQ-011: pc_out  output  32  Registered pc_in.
- REQ-012: alu_ctrl  output  4  ALU operation code: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 EQ, 6 NE, 7 signed LT, 8 signed GE, 9 unsigned LT, 10 unsigned GE, 11 SLL, 12 SRL, 13 SRA.
- REQ-013: rs1, rs2, rd  output  5 each  Register indices.
- REQ-014: imm  output  32  Sign-extended immediate.
- REQ-015: src1_pc, src2_imm  output  1 each  ALU operand selects: pc instead of rs1; imm instead of rs2.
- REQ-016: reg_we, is_branch, is_jal, is_jalr, is_load, is_store, illegal  output  1 each  Decoded class flags.

Function
- REQ-017: Capture SHALL occur when in_valid && in_ready; the bundle SHALL appear on the outputs one cycle later with out_valid=1.
- REQ-018: in_ready SHALL equal !out_valid || out_ready (combinational); back-to-back capture every cycle SHALL be supported with no bubble.
- REQ-019: A held bundle (out_valid && !out_ready) SHALL keep every output stable.
- REQ-020: out_valid SHALL clear after a transfer with no new capture.
- REQ-021: flush=1 SHALL clear out_valid on the next edge, drop any same-cycle capture, and take precedence over all other events.
- REQ-022: OP/OP-IMM SHALL map ADD/ADDI->2, SUB->3, AND->0, OR->1, XOR->4, SLL->11, SRL->12, SRA->13, SLT->7, SLTU->9; reg_we=1; src2_imm=1 for OP-IMM only.
- REQ-023: Branches SHALL map BEQ->5, BNE->6, BLT->7, BGE->8, BLTU->9, BGEU->10; is_branch=1; reg_we=0; imm=B-type.
- REQ-024: LOAD, STORE, JALR SHALL use alu_ctrl 2 with src2_imm=1; JAL and AUIPC SHALL use alu_ctrl 2 with src1_pc=1, src2_imm=1; LUI SHALL use alu_ctrl 2, src2_imm=1, rs1 forced to 0.
- REQ-025: The imm field SHALL be built as follows: I, S, B, U and J formats per RV32I; U = inst[31:12]<<12; shift-immediate instructions SHALL have imm = zero-extended inst[24:20].
- REQ-026: reg_we SHALL be forced to 0 when rd==0.
- REQ-027: Unknown opcode, bad funct3/funct7, or inst[1:0]!=2'b11 SHALL set illegal=1, with reg_we, is_branch, is_jal, is_jalr, is_load, is_store and src1_pc all 0, and alu_ctrl=2; the bundle SHALL still be presented with out_valid=1.
- REQ-028: Fields unused by a format (rs2 for I-type, rd for S/B) SHALL be driven as the raw inst bits.

Reset
- REQ-029: While rst_n=0, out_valid and all flags SHALL be 0, and pc_out, imm, alu_ctrl, rs1, rs2, rd SHALL be 0; in_ready SHALL be 1 after deassertion.
- REQ-030: Reset mid-operation SHALL discard any held bundle immediately (asynchronously).

Verification
- REQ-031: inst=0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle: out_valid=1, alu_ctrl=2, rs1=1, rs2=2, rd=3, reg_we=1, src2_imm=0.
- REQ-032: inst=0xFE209EE3 (bne x1,x2,-4) -> alu_ctrl=6, is_branch=1, imm=0xFFFFFFFC, reg_we=0.
- REQ-033: inst=0x4030D093 (srai x1,x1,3) -> alu_ctrl=13, imm=3, src2_imm=1; inst=0x00000013 -> reg_we=0.
- REQ-034: out_ready=0 with the bundle held, in_valid=1 -> in_ready=0 and the outputs stay unchanged for 5 cycles; then out_ready=1 -> the new bundle appears on the next edge.
- REQ-035: flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 on the next edge; inst=0xFFFFFFFF -> illegal=1 and reg_we=0.
- REQ-036: rst_n pulled low while a bundle is held -> out_valid=0 immediately, before the next clock edge.
